// File: rtl/mha_pkg.sv
// mha_pkg: shared element type, default sizes, FSM states and saturating add for mha_residual_add
package mha_pkg;
   localparam int DEF_WIDTH      = 32;
   localparam int DEF_D_MODEL    = 192;
   localparam int DEF_N_TOKENS   = 197;
   localparam int DEF_SKIP_DEPTH = 1024;
   typedef logic signed [DEF_WIDTH-1:0] elem_t;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   // Clamp a+b into the signed range of a w-bit element (w <= 63); caller truncates to w bits.
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
      logic signed [63:0] s, hi, lo;
      s  = a + b;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      return (s > hi) ? hi : ((s < lo) ? lo : s);
   endfunction
endpackage

// File: rtl/mha_skip_fifo.sv
// mha_skip_fifo: single-clock FIFO holding skip elements until the matching MHA element arrives
module mha_skip_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0] wptr_q, rptr_q;
   logic do_push, do_pop;
   assign empty   = wptr_q == rptr_q;
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rptr_q[AW-1:0]];
   // Storage array; a pop on a full FIFO frees the slot a simultaneous push lands in.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
   end
   // Wrap-bit pointers; flush empties the FIFO at the start of a matrix.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else if (flush) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
         if (do_pop) rptr_q <= rptr_q + (AW+1)'(1);
      end
   end
endmodule

// File: rtl/mha_residual_add.sv
// mha_residual_add: streaming skip connection out = x + MHA(x); define MHA_RESIDUAL_SAT_EN for saturating sums (wraps otherwise)
module mha_residual_add
   import mha_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int D_MODEL    = DEF_D_MODEL,
   parameter int N_TOKENS   = DEF_N_TOKENS,
   parameter int SKIP_DEPTH = DEF_SKIP_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             init,
   output logic             ready,
   input  logic             skip_valid,
   input  logic [WIDTH-1:0] skip_data,
   output logic             skip_ready,
   input  logic             mha_valid,
   input  logic [WIDTH-1:0] mha_data,
   output logic             mha_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             done,
   output logic             err_underflow
);
   localparam int TOTAL = N_TOKENS * D_MODEL;
   localparam int CW    = $clog2(TOTAL + 1);
   localparam int UW    = $clog2(SKIP_DEPTH + 1);
   state_t state_q;
   logic [CW-1:0] elem_cnt_q, push_cnt_q;
   logic [UW-1:0] uf_cnt_q;
   logic out_valid_q, done_q, err_q;
   logic signed [WIDTH-1:0] out_data_q, sum_d, skip_head, mha_s;
   logic fifo_full, fifo_empty, flush, push, pop, acc, last_acc, uf;
   mha_skip_fifo #(.WIDTH(WIDTH), .DEPTH(SKIP_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .wdata (skip_data),
      .rdata (skip_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
   assign mha_s      = mha_data;
   assign flush      = state_q == IDLE && init;
   assign skip_ready = state_q == RUN && !fifo_full && push_cnt_q != CW'(TOTAL);
   assign push       = skip_valid && skip_ready;
   assign pop        = state_q == RUN && mha_valid && !fifo_empty && (!out_valid_q || out_ready);
   assign acc        = out_valid_q && out_ready;
   assign last_acc   = state_q == RUN && acc && elem_cnt_q == CW'(TOTAL - 1);
   assign uf         = push_cnt_q == CW'(TOTAL) && mha_valid && fifo_empty;
`ifdef MHA_RESIDUAL_SAT_EN
   assign sum_d = WIDTH'(sat_add(skip_head, mha_s, WIDTH));
`else
   assign sum_d = skip_head + mha_s;
`endif
   assign ready         = state_q == IDLE;
   assign mha_ready     = pop;
   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign done          = done_q;
   assign err_underflow = err_q;
   // Control FSM with the registered sum stage, element counters and the underflow watchdog.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         elem_cnt_q  <= '0;
         push_cnt_q  <= '0;
         uf_cnt_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (init) begin
               state_q    <= RUN;
               elem_cnt_q <= '0;
               push_cnt_q <= '0;
               uf_cnt_q   <= '0;
               err_q      <= 1'b0;
            end
            RUN: begin
               if (push) push_cnt_q <= push_cnt_q + CW'(1);
               if (acc) begin
                  out_valid_q <= 1'b0;
                  elem_cnt_q  <= elem_cnt_q + CW'(1);
               end
               if (pop) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= sum_d;
               end
               if (last_acc) begin
                  state_q <= DRAIN;
                  done_q  <= 1'b1;
               end
               if (!uf) uf_cnt_q <= '0;
               else if (uf_cnt_q == UW'(SKIP_DEPTH)) err_q <= 1'b1;
               else uf_cnt_q <= uf_cnt_q + UW'(1);
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mha_residual_add.sv
// tb_mha_residual_add: scoreboard bench for mha_residual_add (WIDTH=8, 4 tokens x 2, 4-deep skip FIFO)
`timescale 1ns/1ps
module tb_mha_residual_add;
   localparam int W = 8, DM = 2, NT = 4, SD = 4, TOT = DM * NT;
`ifdef MHA_RESIDUAL_SAT_EN
   localparam int POS = 127, NEG = -128;
`else
   localparam int POS = -56, NEG = 56;
`endif
   logic clk = 1'b0;
   logic reset, init, skip_valid, mha_valid, out_ready;
   logic signed [W-1:0] skip_data, mha_data, out_data;
   logic ready, skip_ready, mha_ready, out_valid, done, err_underflow;
   int checks = 0, failures = 0, n_out = 0, span;
   int sk[TOT], mh[TOT], out_log[TOT];
   int skq[$];
   logic signed [31:0] expq[$];
   always #5 clk = ~clk;
   mha_residual_add #(.WIDTH(W), .D_MODEL(DM), .N_TOKENS(NT), .SKIP_DEPTH(SD)) dut (
      .clk(clk), .reset(reset), .init(init), .ready(ready),
      .skip_valid(skip_valid), .skip_data(skip_data), .skip_ready(skip_ready),
      .mha_valid(mha_valid), .mha_data(mha_data), .mha_ready(mha_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .done(done), .err_underflow(err_underflow)
   );
   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
      end
   endtask
   function automatic int exp_sum(input int a, input int b);
      int s;
      logic signed [W-1:0] t;
      s = a + b;
      t = s[W-1:0];
`ifdef MHA_RESIDUAL_SAT_EN
      return (s > 127) ? 127 : ((s < -128) ? -128 : s);
`else
      return int'(t);
`endif
   endfunction
   // Scoreboard: skip handshakes feed a model FIFO, MHA handshakes produce expected sums, outputs are compared.
   always @(negedge clk) begin
      logic signed [31:0] e;
      if (!reset) begin
         if (out_valid && out_ready) begin
            if (expq.size() > 0) e = expq.pop_front();
            else e = 'x;
            chk("out_data", out_data, e);
            if (n_out < TOT) out_log[n_out] = out_data;
            n_out++;
         end
         if (mha_valid && mha_ready) begin
            if (skq.size() > 0) e = exp_sum(skq.pop_front(), mha_data);
            else e = 'x;
            expq.push_back(e);
         end
         if (skip_valid && skip_ready) skq.push_back(skip_data);
      end
   end
   task automatic pulse_init();
      init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0;
   endtask
   task automatic stream(input int stop_mi, input int stop_out, input int stall_at, input int stall_len,
                         input int mdelay, input bit refill_chk, output int span_o);
      int si = 0, mi = 0, c = 0, st = 0, first_c = -1, last_c = -1;
      bit hs_s, hs_m, stall;
      logic signed [W-1:0] hold = '0;
      n_out = 0;
      while (!(mi >= stop_mi && n_out >= stop_out) && c < 200) begin
         stall      = (n_out == stall_at) && (st < stall_len);
         out_ready  = !stall;
         skip_valid = si < TOT;
         skip_data  = W'(sk[(si < TOT) ? si : 0]);
         mha_valid  = (mi < TOT) && (c >= mdelay);
         mha_data   = W'(mh[(mi < TOT) ? mi : 0]);
         @(negedge clk);
         if (refill_chk && (c == mdelay - 1 || c == mdelay)) chk("skip_ready_full", skip_ready, 0);
         if (refill_chk && c == mdelay + 1) chk("skip_ready_refill", skip_ready, 1);
         if (stall && out_valid) begin
            if (st == 0) hold = out_data;
            else chk("stall_hold", out_data, hold);
            chk("stall_mha_ready", mha_ready, 0);
            st++;
         end
         if (out_valid && out_ready) begin
            if (first_c < 0) first_c = c;
            last_c = c;
         end
         hs_s = skip_valid && skip_ready;
         hs_m = mha_valid && mha_ready;
         @(posedge clk); #1;
         si += int'(hs_s);
         mi += int'(hs_m);
         c++;
      end
      chk("stream_in_time", c < 200, 1);
      skip_valid = 1'b0;
      mha_valid  = 1'b0;
      span_o     = last_c - first_c;
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      reset = 1'b1; init = 1'b0; skip_valid = 1'b0; mha_valid = 1'b0; out_ready = 1'b1;
      skip_data = '0; mha_data = '0;
      @(negedge clk); @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_skip_ready", skip_ready, 0);
      chk("rst_mha_ready", mha_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_underflow, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      // matrix 1: fill FIFO, MHA delayed 5 cycles, then back-to-back sums
      for (int i = 0; i < TOT; i++) begin
         sk[i] = i + 1;
         mh[i] = 10 * (i + 1);
      end
      pulse_init();
      chk("run_ready", ready, 0);
      stream(TOT, TOT, -1, 0, 5, 1'b1, span);
      chk("no_bubbles_span", span, TOT - 1);
      chk("m1_done", done, 1);
      chk("m1_ready_drain", ready, 0);
      @(posedge clk); #1;
      chk("m1_done_pulse", done, 0);
      chk("m1_ready_idle", ready, 1);
      chk("m1_sum0", out_log[0], 11);
      chk("m1_sum7", out_log[7], 88);
      // matrix 2: overflow edges and a 3-cycle downstream stall
      sk = '{100, -100, 3, 4, 5, 6, 7, 8};
      mh = '{100, -100, 1, 1, 1, 1, 1, 1};
      pulse_init();
      stream(TOT, TOT, 2, 3, 0, 1'b0, span);
      chk("m2_done", done, 1);
      chk("pos_overflow", out_log[0], POS);
      chk("neg_overflow", out_log[1], NEG);
      @(posedge clk); #1;
      // matrix 3: reset after 3 outputs, then a clean full matrix
      for (int i = 0; i < TOT; i++) begin
         sk[i] = 2 * i - 7;
         mh[i] = 3 * i;
      end
      pulse_init();
      stream(0, 3, -1, 0, 0, 1'b0, span);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_ready", ready, 1);
      chk("mid_rst_skip_ready", skip_ready, 0);
      chk("mid_rst_mha_ready", mha_ready, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_done", done, 0);
      skq.delete();
      expq.delete();
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      pulse_init();
      stream(TOT, TOT, -1, 0, 0, 1'b0, span);
      chk("m3_done", done, 1);
      chk("m3_no_bubbles", span, TOT - 1);
      @(posedge clk); #1;
      // matrix 4: last sum stalled while MHA keeps presenting data past the matrix
      for (int i = 0; i < TOT; i++) begin
         sk[i] = i;
         mh[i] = 20 + i;
      end
      pulse_init();
      stream(TOT, TOT - 1, TOT - 1, 1000, 0, 1'b0, span);
      out_ready = 1'b0;
      mha_valid = 1'b1;
      mha_data  = 8'sd99;
      for (int i = 0; i < SD; i++) begin
         @(posedge clk); #1;
      end
      chk("uf_not_yet", err_underflow, 0);
      chk("uf_mha_ready", mha_ready, 0);
      @(posedge clk); #1;
      chk("uf_set", err_underflow, 1);
      out_ready = 1'b1;
      mha_valid = 1'b0;
      @(posedge clk); #1;
      chk("m4_done", done, 1);
      chk("uf_sticky", err_underflow, 1);
      @(posedge clk); #1;
      chk("m4_ready_idle", ready, 1);
      pulse_init();
      chk("uf_cleared", err_underflow, 0);
      chk("scoreboard_drained", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
